// File: rtl/code_entry_controller.sv
// Purpose : keypad front end; builds a DIGITS-digit decimal code from debounced key pulses, with blinking cursor.
// Latency : 1 cycle from a sampled key pulse (or ack) to every output; no input-to-output combinational path.
// Backpr. : code_valid/entered_code held until code_ack; all keys are ignored while a code is pending.
//
// Ports:
//   clock, reset        rising-edge clock; asynchronous active-low reset
//   key_inc/next/enter/clear  one-cycle key pulses (priority clear > enter > next > inc)
//   code_ack            downstream consumed entered_code (only honoured while a code is pending)
//   digit_hex           nibble k drives display k; nibble DIGITS-1 is leftmost
//   digit_blank         per-display blank mask (cursor blink)
//   cursor              index of the digit being edited
//   entered_code        submitted code, same packing as digit_hex
//   code_valid          entered_code valid, held until acknowledged
module code_entry_controller #(
    parameter int DIGITS       = 4,
    parameter int MAX_DIGIT    = 9,
    parameter int BLINK_CYCLES = 25000000
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        key_inc,
    input  logic                        key_next,
    input  logic                        key_enter,
    input  logic                        key_clear,
    input  logic                        code_ack,
    output logic [4*DIGITS-1:0]         digit_hex,
    output logic [DIGITS-1:0]           digit_blank,
    output logic [$clog2(DIGITS)-1:0]   cursor,
    output logic [4*DIGITS-1:0]         entered_code,
    output logic                        code_valid
);

    localparam int CW = $clog2(DIGITS);
    localparam int BW = $clog2(BLINK_CYCLES);

    localparam logic [CW-1:0] CURSOR_HOME = CW'(DIGITS - 1);
    localparam logic [3:0]    DIGIT_MAX   = 4'(MAX_DIGIT);
    localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_CYCLES - 1);

    typedef enum logic {
        ENTRY    = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    state_t                  state;
    logic [DIGITS-1:0][3:0]  digit_q;
    logic [BW-1:0]           blink_cnt;
    logic                    blink_phase;
    logic                    key_any;

    // Any key that would be accepted in ENTRY; used to restart the blink so
    // the edited digit is lit right after a keypress.
    assign key_any   = key_clear | key_enter | key_next | key_inc;
    assign digit_hex = digit_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ENTRY;
            digit_q      <= '0;
            cursor       <= CURSOR_HOME;
            blink_cnt    <= '0;
            blink_phase  <= 1'b0;
            entered_code <= '0;
            code_valid   <= 1'b0;
        end else begin
            case (state)
                ENTRY: begin
                    if (key_clear) begin
                        digit_q <= '0;
                        cursor  <= CURSOR_HOME;
                    end else if (key_enter) begin
                        entered_code <= digit_q;
                        code_valid   <= 1'b1;
                        state        <= WAIT_ACK;
                    end else if (key_next) begin
                        // Cursor walks right, i.e. towards nibble 0, then wraps to the leftmost digit.
                        cursor <= (cursor == '0) ? CURSOR_HOME : cursor - 1'b1;
                    end else if (key_inc) begin
                        digit_q[cursor] <= (digit_q[cursor] >= DIGIT_MAX) ? 4'd0
                                                                          : digit_q[cursor] + 4'd1;
                    end

                    if (key_any) begin
                        blink_cnt   <= '0;
                        blink_phase <= 1'b0;
                    end else if (blink_cnt == BLINK_LAST) begin
                        blink_cnt   <= '0;
                        blink_phase <= ~blink_phase;
                    end else begin
                        blink_cnt <= blink_cnt + 1'b1;
                    end
                end

                WAIT_ACK: begin
                    // Display freezes on the submitted code; blink parked so nothing blanks.
                    blink_cnt   <= '0;
                    blink_phase <= 1'b0;
                    if (code_ack) begin
                        code_valid <= 1'b0;
                        digit_q    <= '0;
                        cursor     <= CURSOR_HOME;
                        state      <= ENTRY;
                    end
                end

                default: state <= ENTRY;
            endcase
        end
    end

    // Pure decode of registered phase and cursor; no key input reaches it combinationally.
    always_comb begin
        digit_blank = '0;
        if (blink_phase) digit_blank[cursor] = 1'b1;
    end

endmodule
